// File: rtl/id_imm_stage_pkg.sv
// ------------------------------------------------------------------
// id_imm_stage_pkg : ExtOp codes and primary-opcode constants for the decode stage
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package id_imm_stage_pkg;

  localparam int EXT_OP_W = 2;

  // Codes match the ExtOp_* values in ctrl_encode_def.v
  typedef enum logic [EXT_OP_W-1:0] {
    EXT_OP_UNSIGN = 2'd0,
    EXT_OP_SIGNED = 2'd1,
    EXT_OP_HIGH16 = 2'd2
  } ext_op_e;

  localparam logic [5:0] OP_CMPLI = 6'd10;
  localparam logic [5:0] OP_CMPI  = 6'd11;
  localparam logic [5:0] OP_ADDI  = 6'd14;
  localparam logic [5:0] OP_ADDIS = 6'd15;
  localparam logic [5:0] OP_ORI   = 6'd24;
  localparam logic [5:0] OP_ANDI  = 6'd28;
  localparam logic [5:0] OP_LWZ   = 6'd32;
  localparam logic [5:0] OP_STW   = 6'd36;

endpackage

`default_nettype wire

// File: rtl/id_imm_stage_ext_op_decode.sv
// ------------------------------------------------------------------
// ext_op_decode : combinational primary opcode -> ExtOp mapping
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module ext_op_decode
  import id_imm_stage_pkg::*;
(
  input  logic [5:0]          opcode,
  output logic [EXT_OP_W-1:0] ext_op
);

  always_comb begin
    ext_op = EXT_OP_UNSIGN;
    case (opcode)
      OP_ADDI, OP_LWZ, OP_STW, OP_CMPI: ext_op = EXT_OP_SIGNED;
      OP_ADDIS:                         ext_op = EXT_OP_HIGH16;
      default:                          ext_op = EXT_OP_UNSIGN;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/id_imm_stage.sv
// ------------------------------------------------------------------
// id_imm_stage : decode pipeline register with 2-entry skid buffer feeding the Ext unit.
// Optional IDSTAGE_PERF_EN adds stall/flush performance counters.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module id_imm_stage
  import id_imm_stage_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  output logic                if_ready,
  input  logic [PC_W-1:0]     if_pc,
  input  logic [INSTR_W-1:0]  if_instr,
  input  logic                flush,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [PC_W-1:0]     id_pc,
  output logic [INSTR_W-1:0]  id_instr,
  output logic [15:0]         id_imm16,
`ifdef IDSTAGE_PERF_EN
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_flush_cnt,
`endif
  output logic [EXT_OP_W-1:0] id_ext_op
);

  if (INSTR_W != 32) begin : g_instr_w_bad
    $error("id_imm_stage: INSTR_W must be 32");
  end

  logic                if_ready_q,   if_ready_d;
  logic                id_valid_q,   id_valid_d;
  logic [PC_W-1:0]     head_pc_q,    head_pc_d;
  logic [INSTR_W-1:0]  head_instr_q, head_instr_d;
  logic [EXT_OP_W-1:0] head_ext_q,   head_ext_d;
  logic                skid_valid_q, skid_valid_d;
  logic [PC_W-1:0]     skid_pc_q,    skid_pc_d;
  logic [INSTR_W-1:0]  skid_instr_q, skid_instr_d;
  logic [EXT_OP_W-1:0] skid_ext_q,   skid_ext_d;
  logic [EXT_OP_W-1:0] in_ext;
  logic                in_xfer;

  // Decoded on the input side so the code travels with the entry
  ext_op_decode u_ext_op_decode (
    .opcode (if_instr[31:26]),
    .ext_op (in_ext)
  );

  always_comb begin
    in_xfer      = if_valid & if_ready_q;
    id_valid_d   = id_valid_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    head_ext_d   = head_ext_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_ext_d   = skid_ext_q;

    if (flush) begin
      id_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!id_valid_q || id_ready) begin
      // if_ready is low whenever the skid is full, so both branches never compete
      if (skid_valid_q) begin
        id_valid_d   = 1'b1;
        head_pc_d    = skid_pc_q;
        head_instr_d = skid_instr_q;
        head_ext_d   = skid_ext_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        id_valid_d   = 1'b1;
        head_pc_d    = if_pc;
        head_instr_d = if_instr;
        head_ext_d   = in_ext;
      end else begin
        id_valid_d   = 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = if_pc;
      skid_instr_d = if_instr;
      skid_ext_d   = in_ext;
    end

    if_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_ready_q   <= 1'b0;
      id_valid_q   <= 1'b0;
      head_pc_q    <= '0;
      head_instr_q <= '0;
      head_ext_q   <= EXT_OP_UNSIGN;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_ext_q   <= EXT_OP_UNSIGN;
    end else begin
      if_ready_q   <= if_ready_d;
      id_valid_q   <= id_valid_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      head_ext_q   <= head_ext_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_ext_q   <= skid_ext_d;
    end
  end

  assign if_ready  = if_ready_q;
  assign id_valid  = id_valid_q;
  assign id_pc     = head_pc_q;
  assign id_instr  = head_instr_q;
  assign id_imm16  = head_instr_q[15:0];
  assign id_ext_op = head_ext_q;

`ifdef IDSTAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (id_valid_q && !id_ready) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && (id_valid_q || skid_valid_q)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_imm_stage.sv
// ------------------------------------------------------------------
// tb_id_imm_stage : directed scoreboard bench for id_imm_stage
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_id_imm_stage;
  import id_imm_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [15:0] id_imm16;
  logic [1:0]  id_ext_op;
`ifdef IDSTAGE_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  id_imm_stage #(.PC_W(32), .INSTR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_pc    (if_pc),
    .if_instr (if_instr),
    .flush    (flush),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_pc    (id_pc),
    .id_instr (id_instr),
    .id_imm16 (id_imm16),
`ifdef IDSTAGE_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .id_ext_op (id_ext_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  ext;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] stall_exp = 0;
  logic [31:0] flush_exp = 0;

  function automatic logic [1:0] model_ext(input logic [31:0] instr);
    case (instr[31:26])
      6'd14, 6'd32, 6'd36, 6'd11: return EXT_OP_SIGNED;
      6'd15:                      return EXT_OP_HIGH16;
      default:                    return EXT_OP_UNSIGN;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard step for the upcoming edge, then advance to 1ns past it
  task automatic tick();
    exp_t e;
    if (rst) begin
      sb.delete();
      stall_exp = 0;
      flush_exp = 0;
    end else begin
      if (id_valid && !id_ready) stall_exp++;
      if (flush) begin
        if (sb.size() > 0) flush_exp++;
        sb.delete();
      end else begin
        if (id_valid && id_ready) begin
          tests++;
          assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL sb_unexpected observed=%0h expected=none", id_instr);
          end
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_pc", {32'd0, id_pc}, {32'd0, e.pc});
            chk("out_instr", {32'd0, id_instr}, {32'd0, e.instr});
            chk("out_imm16", {48'd0, id_imm16}, {48'd0, e.instr[15:0]});
            chk("out_ext", {62'd0, id_ext_op}, {62'd0, e.ext});
          end
        end
        if (if_valid && if_ready) begin
          e.pc = if_pc;
          e.instr = if_instr;
          e.ext = model_ext(if_instr);
          sb.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
    if_valid = 1'b1;
    if_pc    = pc;
    if_instr = instr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] stall_base;
  logic [31:0] stream_instr[4];

  initial begin
    stream_instr[0] = 32'h80410008;
    stream_instr[1] = 32'h90410010;
    stream_instr[2] = 32'h60210005;
    stream_instr[3] = 32'h2C03FFF0;
    rst = 1'b1; flush = 1'b0; id_ready = 1'b1;
    offer(32'h55, 32'h38000001);

    // Reset
    tick();
    chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
    chk("rst_if_ready", {63'd0, if_ready}, 64'd0);
    tick();
    chk("rst_if_ready2", {63'd0, if_ready}, 64'd0);
    chk("rst_id_pc", {32'd0, id_pc}, 64'd0);
    chk("rst_id_instr", {32'd0, id_instr}, 64'd0);
    chk("rst_imm16", {48'd0, id_imm16}, 64'd0);
    chk("rst_ext", {62'd0, id_ext_op}, {62'd0, EXT_OP_UNSIGN});
    rst = 1'b0; if_valid = 1'b0;
    tick();
    chk("post_rst_if_ready", {63'd0, if_ready}, 64'd1);
    chk("post_rst_id_valid", {63'd0, id_valid}, 64'd0);

    // Streaming
    offer(32'h100, 32'h3860FFFF);
    tick();
    if_valid = 1'b0;
    chk("addi_valid", {63'd0, id_valid}, 64'd1);
    chk("addi_imm16", {48'd0, id_imm16}, 64'hFFFF);
    chk("addi_ext", {62'd0, id_ext_op}, {62'd0, EXT_OP_SIGNED});
    tick();
    for (int i = 0; i < 4; i++) begin
      offer(32'h200 + 32'(4 * i), stream_instr[i]);
      tick();
      chk("stream_no_bubble", {63'd0, id_valid}, 64'd1);
      chk("stream_pc", {32'd0, id_pc}, {32'd0, 32'h200 + 32'(4 * i)});
    end
    if_valid = 1'b0;
    tick();
    chk("stream_drained", {63'd0, id_valid}, 64'd0);

    // Backpressure into the skid
    id_ready = 1'b0;
    offer(32'h300, 32'h3C201234);
    tick();
    chk("bp_ready_one", {63'd0, if_ready}, 64'd1);
    offer(32'h304, 32'h60210005);
    tick();
    chk("bp_full_if_ready", {63'd0, if_ready}, 64'd0);
    chk("bp_head_instr", {32'd0, id_instr}, 64'h3C201234);
    chk("bp_head_ext", {62'd0, id_ext_op}, {62'd0, EXT_OP_HIGH16});
    offer(32'h308, 32'h28000007);
    tick();
    chk("bp_hold_instr", {32'd0, id_instr}, 64'h3C201234);
    if_valid = 1'b0; id_ready = 1'b1;
    tick();
    chk("bp_ori_imm16", {48'd0, id_imm16}, 64'h0005);
    chk("bp_ori_ext", {62'd0, id_ext_op}, {62'd0, EXT_OP_UNSIGN});
    chk("bp_ready_back", {63'd0, if_ready}, 64'd1);
    tick();
    chk("bp_drained", {63'd0, id_valid}, 64'd0);

    // Flush with both entries full
    id_ready = 1'b0;
    offer(32'h400, 32'h70000003);
    tick();
    offer(32'h404, 32'h2C030000);
    tick();
    offer(32'h408, 32'h38000009);
    flush = 1'b1;
    tick();
    flush = 1'b0; if_valid = 1'b0;
    chk("flush_id_valid", {63'd0, id_valid}, 64'd0);
    chk("flush_if_ready", {63'd0, if_ready}, 64'd1);
    id_ready = 1'b1;
    tick();
    chk("flush_nothing_out", {63'd0, id_valid}, 64'd0);

    // Flush discards a simultaneous accepted input
    id_ready = 1'b0;
    offer(32'h500, 32'h60000001);
    tick();
    offer(32'h504, 32'h38000002);
    flush = 1'b1;
    tick();
    flush = 1'b0; if_valid = 1'b0;
    chk("flush2_id_valid", {63'd0, id_valid}, 64'd0);
    tick();
    chk("flush2_still_empty", {63'd0, id_valid}, 64'd0);

    // Unknown opcode, then stalled cycles
    id_ready = 1'b1;
    offer(32'h600, 32'h7C000000);
    tick();
    if_valid = 1'b0;
    chk("unk_valid", {63'd0, id_valid}, 64'd1);
    chk("unk_ext", {62'd0, id_ext_op}, {62'd0, EXT_OP_UNSIGN});
`ifdef IDSTAGE_PERF_EN
    stall_base = perf_stall_cnt;
`else
    stall_base = 32'd0;
`endif
    id_ready = 1'b0;
    tick(); tick(); tick();
`ifdef IDSTAGE_PERF_EN
    chk("perf_stall3", {32'd0, perf_stall_cnt - stall_base}, 64'd3);
`endif
    chk("stall_hold_pc", {32'd0, id_pc}, 64'h600);
    id_ready = 1'b1;
    offer(32'h604, 32'h28000007);
    tick();
    if_valid = 1'b0;
    chk("cmpli_ext", {62'd0, id_ext_op}, {62'd0, EXT_OP_UNSIGN});
    tick();

    // Reset mid-transfer drops held entries
    id_ready = 1'b0;
    offer(32'h700, 32'h38000011);
    tick();
    offer(32'h704, 32'h38000012);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_id_valid", {63'd0, id_valid}, 64'd0);
    chk("mid_rst_if_ready", {63'd0, if_ready}, 64'd0);
    rst = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
    tick();
    chk("mid_rst_ready_back", {63'd0, if_ready}, 64'd1);
    tick();
    chk("mid_rst_empty", {63'd0, id_valid}, 64'd0);

`ifdef IDSTAGE_PERF_EN
    chk("perf_stall_final", {32'd0, perf_stall_cnt}, {32'd0, stall_exp});
    chk("perf_flush_final", {32'd0, perf_flush_cnt}, {32'd0, flush_exp});
`endif
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
